// File: rtl/mmss_timer_pkg.sv
// Shared types and constants for the mm:ss BCD timer.
package mmss_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] BCD_NINE = 4'd9;
  localparam logic [3:0] BCD_FIVE = 4'd5;

  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

  function automatic int calc_presc_width(input int div);
    return (div > 2) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/mmss_timer_bcd_bcd2_updown.sv
// Two-digit BCD field counting 00..MAX, stepping up or down, with set-increment and clear.
module bcd2_updown
  import mmss_timer_pkg::*;
#(
  parameter int MAX = 59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       step,
  input  logic       up,
  input  logic       set_inc,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic       at_max,
  output logic       at_zero
);

  localparam logic [3:0] MAX_T = 4'(MAX / 10);
  localparam logic [3:0] MAX_U = 4'(MAX % 10);

  logic [3:0] t_s;
  logic [3:0] u_s;
  logic [3:0] tens_nxt_s;
  logic [3:0] units_nxt_s;
  logic       up_s;

  // Out-of-range digits are treated as zero so a corrupted field recovers on its next update.
  always_comb begin
    t_s     = (tens > MAX_T) ? 4'd0 : tens;
    u_s     = (units > BCD_NINE) ? 4'd0 : units;
    at_max  = (t_s == MAX_T) && (u_s >= MAX_U);
    at_zero = (t_s == 4'd0) && (u_s == 4'd0);
    up_s    = step ? up : 1'b1;
  end

  // Next field value for one step in the selected direction, wrapping at both ends.
  always_comb begin
    tens_nxt_s  = t_s;
    units_nxt_s = u_s;
    if (up_s) begin
      if (at_max) begin
        tens_nxt_s  = 4'd0;
        units_nxt_s = 4'd0;
      end else if (u_s == BCD_NINE) begin
        tens_nxt_s  = t_s + 4'd1;
        units_nxt_s = 4'd0;
      end else begin
        units_nxt_s = u_s + 4'd1;
      end
    end else begin
      if (at_zero) begin
        tens_nxt_s  = MAX_T;
        units_nxt_s = MAX_U;
      end else if (u_s == 4'd0) begin
        tens_nxt_s  = t_s - 4'd1;
        units_nxt_s = BCD_NINE;
      end else begin
        units_nxt_s = u_s - 4'd1;
      end
    end
  end

  // Digit registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tens  <= 4'd0;
      units <= 4'd0;
    end else if (clr) begin
      tens  <= 4'd0;
      units <= 4'd0;
    end else if (step || set_inc) begin
      tens  <= tens_nxt_s;
      units <= units_nxt_s;
    end else begin
      tens  <= tens;
      units <= units;
    end
  end

endmodule

// File: rtl/mmss_timer_bcd.sv
// mm:ss up/down BCD timer with prescaler tick, set buttons, auto-stop or wrap, and status pulses.
module mmss_timer_bcd
  import mmss_timer_pkg::*;
#(
  parameter int CLK_HZ      = 100000000,
  parameter int TICK_HZ     = 1,
  parameter int MAX_MINUTES = 59,
  parameter int AUTO_STOP   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic       forward,
  input  logic       inc_seconds,
  input  logic       inc_minutes,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_units,
  output logic [3:0] min_tens,
  output logic [3:0] min_units,
  output logic       finish,
  output logic       done,
  output logic       running,
  output logic       tick
);

  localparam int            DIV          = calc_div(CLK_HZ, TICK_HZ);
  localparam int            PW           = calc_presc_width(DIV);
  localparam logic [PW-1:0] PRESC_LAST   = PW'(DIV - 1);
  localparam int            SEC_MAX      = int'(BCD_FIVE) * 10 + int'(BCD_NINE);
  localparam bit            STOP_AT_TERM = (AUTO_STOP != 0);

  state_t        state_r;
  state_t        state_nxt_s;
  logic [PW-1:0] presc_r;
  logic          inc_sec_q_r;
  logic          inc_min_q_r;
  logic          finish_r;
  logic          done_r;
  logic          running_r;
  logic          tick_r;

  logic inc_sec_s;
  logic inc_min_s;
  logic inc_any_s;
  logic run_s;
  logic fire_s;
  logic term_s;
  logic hold_s;
  logic sec_step_s;
  logic min_step_s;
  logic sec_at_max_s;
  logic sec_at_zero_s;
  logic min_at_max_s;
  logic min_at_zero_s;

  // Button edges, tick qualification and terminal decode; forward on the tick cycle picks the terminal.
  always_comb begin
    inc_sec_s  = inc_seconds & ~inc_sec_q_r & (state_r != RUN);
    inc_min_s  = inc_minutes & ~inc_min_q_r & (state_r != RUN);
    inc_any_s  = inc_sec_s | inc_min_s;
    run_s      = (state_r == RUN) & enable;
    fire_s     = run_s & (presc_r == PRESC_LAST);
    term_s     = forward ? (sec_at_max_s & min_at_max_s) : (sec_at_zero_s & min_at_zero_s);
    hold_s     = fire_s & term_s & STOP_AT_TERM;
    sec_step_s = fire_s & ~hold_s;
    min_step_s = sec_step_s & (forward ? sec_at_max_s : sec_at_zero_s);
  end

  // Next-state logic; DONE only leaves on pause or an accepted set button.
  always_comb begin
    state_nxt_s = state_r;
    if (clear) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    state_nxt_s = enable ? RUN : IDLE;
        RUN: begin
          if (!enable) begin
            state_nxt_s = IDLE;
          end else if (hold_s) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = RUN;
          end
        end
        DONE:    state_nxt_s = (!enable || inc_any_s) ? IDLE : DONE;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Prescaler, edge-detect history and registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_r     <= {PW{1'b0}};
      inc_sec_q_r <= 1'b0;
      inc_min_q_r <= 1'b0;
      finish_r    <= 1'b0;
      done_r      <= 1'b0;
      running_r   <= 1'b0;
      tick_r      <= 1'b0;
    end else begin
      inc_sec_q_r <= inc_seconds;
      inc_min_q_r <= inc_minutes;
      finish_r    <= fire_s & term_s & ~clear;
      tick_r      <= fire_s & ~clear;
      done_r      <= (state_nxt_s == DONE);
      running_r   <= (state_nxt_s == RUN);
      // Outside an active RUN cycle the prescaler sits at zero, discarding any partial period.
      if (clear || !run_s || (presc_r == PRESC_LAST)) begin
        presc_r <= {PW{1'b0}};
      end else begin
        presc_r <= presc_r + PW'(1);
      end
    end
  end

  bcd2_updown #(.MAX(SEC_MAX)) u_seconds (
    .clk     (clk),
    .reset   (reset),
    .clr     (clear),
    .step    (sec_step_s),
    .up      (forward),
    .set_inc (inc_sec_s),
    .tens    (sec_tens),
    .units   (sec_units),
    .at_max  (sec_at_max_s),
    .at_zero (sec_at_zero_s)
  );

  bcd2_updown #(.MAX(MAX_MINUTES)) u_minutes (
    .clk     (clk),
    .reset   (reset),
    .clr     (clear),
    .step    (min_step_s),
    .up      (forward),
    .set_inc (inc_min_s),
    .tens    (min_tens),
    .units   (min_units),
    .at_max  (min_at_max_s),
    .at_zero (min_at_zero_s)
  );

  assign finish  = finish_r;
  assign done    = done_r;
  assign running = running_r;
  assign tick    = tick_r;

endmodule

// File: tb/tb_mmss_timer_bcd.sv
// Bench: two timers (auto-stop 59-minute, wrapping 1-minute) against a total-seconds model plus literal checkpoints.
module tb_mmss_timer_bcd;

  localparam int DIVV = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] clear, en, fwd, inc_s, inc_m;
  logic [1:0][3:0] o_st, o_su, o_mt, o_mu;
  logic [1:0] o_fin, o_done, o_run, o_tick;

  int checks = 0;
  int errors = 0;

  int m_val [2];
  int m_st  [2];
  int m_cnt [2];
  bit m_fin [2];
  bit m_tick[2];
  bit p_s   [2];
  bit p_m   [2];

  always #5 clk = ~clk;

  mmss_timer_bcd #(.CLK_HZ(10), .TICK_HZ(1), .MAX_MINUTES(59), .AUTO_STOP(1)) u_a (
    .clk(clk), .reset(reset), .clear(clear[0]), .enable(en[0]), .forward(fwd[0]),
    .inc_seconds(inc_s[0]), .inc_minutes(inc_m[0]),
    .sec_tens(o_st[0]), .sec_units(o_su[0]), .min_tens(o_mt[0]), .min_units(o_mu[0]),
    .finish(o_fin[0]), .done(o_done[0]), .running(o_run[0]), .tick(o_tick[0])
  );

  mmss_timer_bcd #(.CLK_HZ(10), .TICK_HZ(1), .MAX_MINUTES(1), .AUTO_STOP(0)) u_b (
    .clk(clk), .reset(reset), .clear(clear[1]), .enable(en[1]), .forward(fwd[1]),
    .inc_seconds(inc_s[1]), .inc_minutes(inc_m[1]),
    .sec_tens(o_st[1]), .sec_units(o_su[1]), .min_tens(o_mt[1]), .min_units(o_mu[1]),
    .finish(o_fin[1]), .done(o_done[1]), .running(o_run[1]), .tick(o_tick[1])
  );

  function automatic int maxm(input int k);
    return (k == 0) ? 59 : 1;
  endfunction

  function automatic bit autostop(input int k);
    return (k == 0);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  // Model: value kept as total seconds; states 0=idle 1=run 2=done.
  task automatic model_step(input int k);
    int  modv, s, m, nst;
    bit  is_s, is_m, fire, term;
    modv = (maxm(k) + 1) * 60;
    if (clear[k]) begin
      m_val[k] = 0; m_st[k] = 0; m_cnt[k] = 0; m_fin[k] = 1'b0; m_tick[k] = 1'b0;
    end else begin
      is_s = inc_s[k] && !p_s[k] && (m_st[k] != 1);
      is_m = inc_m[k] && !p_m[k] && (m_st[k] != 1);
      fire = (m_st[k] == 1) && en[k] && (m_cnt[k] == DIVV - 1);
      term = fwd[k] ? (m_val[k] == modv - 1) : (m_val[k] == 0);
      m_tick[k] = fire;
      m_fin[k]  = fire && term;
      nst = m_st[k];
      if (m_st[k] == 0 && en[k]) nst = 1;
      else if (m_st[k] == 1 && !en[k]) nst = 0;
      else if (m_st[k] == 1 && fire && term && autostop(k)) nst = 2;
      else if (m_st[k] == 2 && (!en[k] || is_s || is_m)) nst = 0;
      if (fire && !(term && autostop(k))) begin
        m_val[k] = fwd[k] ? (m_val[k] + 1) % modv : (m_val[k] + modv - 1) % modv;
      end else if (is_s || is_m) begin
        s = m_val[k] % 60;
        m = m_val[k] / 60;
        if (is_s) s = (s + 1) % 60;
        if (is_m) m = (m + 1) % (maxm(k) + 1);
        m_val[k] = m * 60 + s;
      end
      m_cnt[k] = (m_st[k] == 1 && en[k]) ? (m_cnt[k] + 1) % DIVV : 0;
      m_st[k]  = nst;
    end
    p_s[k] = inc_s[k];
    p_m[k] = inc_m[k];
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_val[k] = 0; m_st[k] = 0; m_cnt[k] = 0;
      m_fin[k] = 1'b0; m_tick[k] = 1'b0; p_s[k] = 1'b0; p_m[k] = 1'b0;
    end
    forever begin
      @(posedge clk or negedge reset);
      for (int k = 0; k < 2; k++) begin
        if (!reset) begin
          m_val[k] = 0; m_st[k] = 0; m_cnt[k] = 0;
          m_fin[k] = 1'b0; m_tick[k] = 1'b0; p_s[k] = 1'b0; p_m[k] = 1'b0;
        end else begin
          model_step(k);
        end
      end
    end
  end

  function automatic logic [19:0] exp_vec(input int k);
    int s, m;
    s = m_val[k] % 60;
    m = m_val[k] / 60;
    return {4'(s / 10), 4'(s % 10), 4'(m / 10), 4'(m % 10),
            m_fin[k], (m_st[k] == 2), (m_st[k] == 1), m_tick[k]};
  endfunction

  function automatic logic [19:0] act_vec(input int k);
    return {o_st[k], o_su[k], o_mt[k], o_mu[k], o_fin[k], o_done[k], o_run[k], o_tick[k]};
  endfunction

  function automatic logic [15:0] digits(input int k);
    return {o_mt[k], o_mu[k], o_st[k], o_su[k]};
  endfunction

  function automatic logic [3:0] status(input int k);
    return {o_fin[k], o_done[k], o_run[k], o_tick[k]};
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) chk($sformatf("cycle_%0d", k), 32'(act_vec(k)), 32'(exp_vec(k)));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_sec(input int k, input int n);
    repeat (n) begin
      inc_s[k] = 1'b1; step(1);
      inc_s[k] = 1'b0; step(1);
    end
  endtask

  task automatic wait_tick(input int k, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_tick[k] && n < budget);
    if (!o_tick[k]) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout_%0d: no tick in %0d cycles, required a tick", k, budget);
    end
  endtask

  task automatic clear_a();
    clear[0] = 1'b1; step(1);
    clear[0] = 1'b0; step(1);
  endtask

  initial begin
    clear = 2'b00; en = 2'b00; fwd = 2'b00; inc_s = 2'b00; inc_m = 2'b00;
    #1 reset = 1'b0;
    step(2);
    chk("rst_digits_a", 32'(digits(0)), 32'h0000);
    chk("rst_status_a", 32'(status(0)), 32'h0);
    chk("rst_status_b", 32'(status(1)), 32'h0);
    reset = 1'b1;

    // Count up from 00:00.
    fwd[0] = 1'b1; en[0] = 1'b1;
    step(10);
    chk("up_no_tick_early", 32'(o_tick[0]), 32'h0);
    step(1);
    chk("up_first_tick", 32'(o_tick[0]), 32'h1);
    chk("up_tick1_val", 32'(digits(0)), 32'h0001);
    chk("up_running", 32'(o_run[0]), 32'h1);
    repeat (58) wait_tick(0, 12);
    chk("up_tick59_val", 32'(digits(0)), 32'h0059);
    wait_tick(0, 12);
    chk("up_tick60_val", 32'(digits(0)), 32'h0100);
    en[0] = 1'b0; step(1);
    clear_a();
    chk("clear_val", 32'(digits(0)), 32'h0000);

    // Count down from 00:03 to auto-stop.
    pulse_sec(0, 3);
    chk("load_0003", 32'(digits(0)), 32'h0003);
    fwd[0] = 1'b0; en[0] = 1'b1;
    wait_tick(0, 12);
    chk("dn_tick1", 32'(digits(0)), 32'h0002);
    wait_tick(0, 12);
    chk("dn_tick2", 32'(digits(0)), 32'h0001);
    wait_tick(0, 12);
    chk("dn_tick3", 32'(digits(0)), 32'h0000);
    chk("dn_tick3_nofin", 32'(o_fin[0]), 32'h0);
    wait_tick(0, 12);
    chk("dn_tick4_status", 32'(status(0)), 32'b1101);
    chk("dn_tick4_hold", 32'(digits(0)), 32'h0000);
    step(1);
    chk("done_level", 32'(status(0)), 32'b0100);
    step(12);
    chk("done_no_restart", 32'(status(0)), 32'b0100);
    en[0] = 1'b0; step(1);
    chk("done_exit", 32'(status(0)), 32'b0000);

    // Wrapping instance counting down from 00:00.
    fwd[1] = 1'b0; en[1] = 1'b1;
    wait_tick(1, 12);
    chk("wrap_fin", 32'(o_fin[1]), 32'h1);
    chk("wrap_val", 32'(digits(1)), 32'h0159);
    chk("wrap_running", 32'(o_run[1]), 32'h1);
    wait_tick(1, 12);
    chk("wrap_next", 32'(digits(1)), 32'h0158);
    en[1] = 1'b0;

    // Pause mid-period discards the partial prescaler count.
    fwd[0] = 1'b1; en[0] = 1'b1;
    step(6);
    en[0] = 1'b0; step(1);
    chk("pause_idle", 32'(o_run[0]), 32'h0);
    step(5);
    chk("pause_held", 32'(digits(0)), 32'h0000);
    en[0] = 1'b1;
    step(10);
    chk("reen_no_tick", 32'(o_tick[0]), 32'h0);
    step(1);
    chk("reen_tick", 32'(o_tick[0]), 32'h1);
    chk("reen_val", 32'(digits(0)), 32'h0001);
    en[0] = 1'b0; step(1);

    // Set buttons: edge-only, both fields, ignored while running.
    clear_a();
    pulse_sec(0, 59);
    chk("set_0059", 32'(digits(0)), 32'h0059);
    inc_m[0] = 1'b1; step(1); inc_m[0] = 1'b0; step(1);
    chk("set_0159", 32'(digits(0)), 32'h0159);
    inc_s[0] = 1'b1; step(20); inc_s[0] = 1'b0; step(1);
    chk("held_button", 32'(digits(0)), 32'h0100);
    inc_s[0] = 1'b1; inc_m[0] = 1'b1; step(1);
    inc_s[0] = 1'b0; inc_m[0] = 1'b0; step(1);
    chk("both_buttons", 32'(digits(0)), 32'h0201);
    en[0] = 1'b1; step(2);
    inc_s[0] = 1'b1; inc_m[0] = 1'b1; step(1);
    inc_s[0] = 1'b0; inc_m[0] = 1'b0; step(2);
    inc_s[0] = 1'b1; inc_m[0] = 1'b1; step(1);
    inc_s[0] = 1'b0; inc_m[0] = 1'b0; step(3);
    chk("run_ignores_set", 32'(digits(0)), 32'h0201);
    step(2);
    chk("run_after_set", 32'(digits(0)), 32'h0202);
    en[0] = 1'b0; step(1);

    // Asynchronous reset in the middle of a cycle while running at 00:37.
    clear_a();
    pulse_sec(0, 36);
    en[0] = 1'b1;
    wait_tick(0, 12);
    chk("pre_reset_val", 32'(digits(0)), 32'h0037);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_digits", 32'(digits(0)), 32'h0000);
    chk("async_rst_status", 32'(status(0)), 32'h0);
    en[0] = 1'b0;
    step(1);
    reset = 1'b1;
    step(1);

    // Clear on the terminal tick wins and suppresses finish.
    fwd[0] = 1'b0; en[0] = 1'b1;
    step(10);
    clear[0] = 1'b1; step(1);
    chk("clr_term_status", 32'(status(0)), 32'h0);
    chk("clr_term_val", 32'(digits(0)), 32'h0000);
    clear[0] = 1'b0; en[0] = 1'b0;
    step(3);
    chk("clr_term_after", 32'(status(0)), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
